bes_unit_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared bypass/equality/set-less-than operation unit. It accepts operand/select requests from two independent clients, drives the shared unit one operation at a time, captures each 4-bit result, and holds it per client until acknowledged. The block sits between the clients and the unit's A/B/Sel/Out ports. The unit itself remains purely combinational and is instantiated outside this block.

---
 rtl/bes_unit_arbiter_if.sv | 41 ++++
 rtl/bes_unit_arbiter.sv | 111 +++++++++++
 tb/tb_bes_unit_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bes_unit_arbiter_if.sv
// Client and datapath bundle for the shared bypass/equality/slt unit arbiter.
// master is the client/unit side; slave is the arbiter side.
interface bes_unit_arbiter_if;
   logic       Req_0;
   logic       Req_1;
   logic [3:0] A_0;
   logic [3:0] B_0;
   logic [3:0] A_1;
   logic [3:0] B_1;
   logic [1:0] Sel_0;
   logic [1:0] Sel_1;
   logic       Gnt_0;
   logic       Gnt_1;
   logic [3:0] Res_0;
   logic [3:0] Res_1;
   logic       Res_Valid_0;
   logic       Res_Valid_1;
   logic       Res_Ack_0;
   logic       Res_Ack_1;
   logic [3:0] Dp_A;
   logic [3:0] Dp_B;
   logic [1:0] Dp_Sel;
   logic [3:0] Dp_Out;
   logic       Busy;

   modport master (
      output Req_0, Req_1, A_0, B_0, A_1, B_1,
      output Sel_0, Sel_1, Res_Ack_0, Res_Ack_1, Dp_Out,
      input  Gnt_0, Gnt_1, Res_0, Res_1,
      input  Res_Valid_0, Res_Valid_1,
      input  Dp_A, Dp_B, Dp_Sel, Busy
   );

   modport slave (
      input  Req_0, Req_1, A_0, B_0, A_1, B_1,
      input  Sel_0, Sel_1, Res_Ack_0, Res_Ack_1, Dp_Out,
      output Gnt_0, Gnt_1, Res_0, Res_1,
      output Res_Valid_0, Res_Valid_1,
      output Dp_A, Dp_B, Dp_Sel, Busy
   );
endinterface

// File: rtl/bes_unit_arbiter.sv
// Two-client round-robin sequencer for the shared bypass/eq/slt unit.
// One operation per two cycles; results held per client until acked.
module bes_unit_arbiter (
   input logic              clk,
   input logic              rst_n,
   bes_unit_arbiter_if.slave bus
);
   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t     state;
   logic       owner;
   logic       rr_ptr;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic [1:0] op_sel;
   logic [3:0] res_0;
   logic [3:0] res_1;
   logic       vld_0;
   logic       vld_1;
   logic       elig_0;
   logic       elig_1;
   logic       gnt_0;
   logic       gnt_1;

   assign elig_0 = bus.Req_0 & ~vld_0;
   assign elig_1 = bus.Req_1 & ~vld_1;

   // Grant: a sole eligible client wins, rr_ptr breaks a tie; held off in reset
   always_comb begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
      if (rst_n && state == IDLE) begin
         if (elig_0 && elig_1) begin
            gnt_0 = ~rr_ptr;
            gnt_1 = rr_ptr;
         end else begin
            gnt_0 = elig_0;
            gnt_1 = elig_1;
         end
      end
   end

   // Sequencer: latch the winner's operands, then capture the unit's result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         owner  <= 1'b0;
         rr_ptr <= 1'b0;
         op_a   <= 4'd0;
         op_b   <= 4'd0;
         op_sel <= 2'd0;
         res_0  <= 4'd0;
         res_1  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_0 || gnt_1) begin
                  owner  <= gnt_1;
                  op_a   <= gnt_1 ? bus.A_1 : bus.A_0;
                  op_b   <= gnt_1 ? bus.B_1 : bus.B_0;
                  op_sel <= gnt_1 ? bus.Sel_1 : bus.Sel_0;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (owner) begin
                  res_1 <= bus.Dp_Out;
               end else begin
                  res_0 <= bus.Dp_Out;
               end
               rr_ptr <= ~owner;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pending flags: set when the owner's result lands, cleared by its ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_0 <= 1'b0;
         vld_1 <= 1'b0;
      end else begin
         if (state == EXEC && !owner) begin
            vld_0 <= 1'b1;
         end else if (bus.Res_Ack_0 && vld_0) begin
            vld_0 <= 1'b0;
         end
         if (state == EXEC && owner) begin
            vld_1 <= 1'b1;
         end else if (bus.Res_Ack_1 && vld_1) begin
            vld_1 <= 1'b0;
         end
      end
   end

   assign bus.Gnt_0       = gnt_0;
   assign bus.Gnt_1       = gnt_1;
   assign bus.Res_0       = res_0;
   assign bus.Res_1       = res_1;
   assign bus.Res_Valid_0 = vld_0;
   assign bus.Res_Valid_1 = vld_1;
   assign bus.Busy        = (state == EXEC);
   assign bus.Dp_A        = (state == EXEC) ? op_a : 4'd0;
   assign bus.Dp_B        = (state == EXEC) ? op_b : 4'd0;
   assign bus.Dp_Sel      = (state == EXEC) ? op_sel : 2'd0;
endmodule

// File: tb/tb_bes_unit_arbiter.sv
// Bench for bes_unit_arbiter: directed scenarios plus random traffic
// checked each cycle against a job-level reference model.
module tb_bes_unit_arbiter;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   bes_unit_arbiter_if bus ();

   bes_unit_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.Dp_Out = bus.Dp_A + bus.Dp_B;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one job in flight at most, per-client result slots
   bit         m_fl;
   bit         m_c;
   logic [3:0] m_a;
   logic [3:0] m_b;
   logic [1:0] m_s;
   bit         m_pref;
   bit   [1:0] m_v;
   logic [3:0] m_r [2];

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_fl   = 0;
      m_c    = 0;
      m_a    = 0;
      m_b    = 0;
      m_s    = 0;
      m_pref = 0;
      m_v    = 0;
      m_r[0] = 0;
      m_r[1] = 0;
   endtask

   // Compare every output with the model, advance model, move to next negedge
   task automatic tick();
      bit   e0, e1, g0, g1;
      bit   [1:0] nv;
      int   sum;
      e0 = bus.Req_0 && !m_v[0];
      e1 = bus.Req_1 && !m_v[1];
      g0 = 0;
      g1 = 0;
      if (!m_fl) begin
         if (e0 && e1) begin
            g0 = !m_pref;
            g1 = m_pref;
         end else begin
            g0 = e0;
            g1 = e1;
         end
      end
      chk("gnt0", 8'(bus.Gnt_0), 8'(g0));
      chk("gnt1", 8'(bus.Gnt_1), 8'(g1));
      chk("busy", 8'(bus.Busy), 8'(m_fl));
      chk("dp_a", 8'(bus.Dp_A), m_fl ? 8'(m_a) : 8'd0);
      chk("dp_b", 8'(bus.Dp_B), m_fl ? 8'(m_b) : 8'd0);
      chk("dp_sel", 8'(bus.Dp_Sel), m_fl ? 8'(m_s) : 8'd0);
      chk("res0", 8'(bus.Res_0), 8'(m_r[0]));
      chk("res1", 8'(bus.Res_1), 8'(m_r[1]));
      chk("vld0", 8'(bus.Res_Valid_0), 8'(m_v[0]));
      chk("vld1", 8'(bus.Res_Valid_1), 8'(m_v[1]));
      nv = m_v;
      if (bus.Res_Ack_0) nv[0] = 0;
      if (bus.Res_Ack_1) nv[1] = 0;
      if (m_fl) begin
         sum       = (int'(m_a) + int'(m_b)) % 16;
         m_r[m_c]  = sum[3:0];
         nv[m_c]   = 1;
         m_pref    = !m_c;
         m_fl      = 0;
      end else if (g0 || g1) begin
         m_fl = 1;
         m_c  = g1;
         m_a  = g1 ? bus.A_1 : bus.A_0;
         m_b  = g1 ? bus.B_1 : bus.B_0;
         m_s  = g1 ? bus.Sel_1 : bus.Sel_0;
      end
      m_v = nv;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle_inputs();
      bus.Req_0     = 0;
      bus.Req_1     = 0;
      bus.Res_Ack_0 = 0;
      bus.Res_Ack_1 = 0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_inputs();
      bus.A_0   = 0;
      bus.B_0   = 0;
      bus.A_1   = 0;
      bus.B_1   = 0;
      bus.Sel_0 = 0;
      bus.Sel_1 = 0;
      m_reset();
      bus.Req_0 = 1;
      #2;
      chk("rst_noclk_gnt", 8'({bus.Gnt_1, bus.Gnt_0}), 8'd0);
      chk("rst_noclk_busy", 8'(bus.Busy), 8'd0);
      chk("rst_noclk_vld", 8'({bus.Res_Valid_1, bus.Res_Valid_0}), 8'd0);
      bus.Req_0 = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // 1: reset asserted mid-EXEC
      bus.Req_0 = 1;
      bus.A_0   = 4'd5;
      bus.B_0   = 4'd6;
      bus.Sel_0 = 2'b10;
      #1 tick();
      #1;
      chk("t1_busy_pre", 8'(bus.Busy), 8'd1);
      rst_n = 1'b0;
      #1;
      chk("t1_busy", 8'(bus.Busy), 8'd0);
      chk("t1_dp", 8'({bus.Dp_Sel, bus.Dp_A}), 8'd0);
      chk("t1_dpb", 8'(bus.Dp_B), 8'd0);
      chk("t1_gnt", 8'({bus.Gnt_1, bus.Gnt_0}), 8'd0);
      chk("t1_res", 8'({bus.Res_1, bus.Res_0}), 8'd0);
      m_reset();
      bus.Req_0 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         #1 tick();
      end
      #1;
      chk("t1_no_vld", 8'({bus.Res_Valid_1, bus.Res_Valid_0}), 8'd0);

      // 2: single request, latency and hold
      do_reset();
      bus.Req_0 = 1;
      bus.A_0   = 4'd3;
      bus.B_0   = 4'd4;
      bus.Sel_0 = 2'b01;
      #1;
      chk("t2_gnt0", 8'(bus.Gnt_0), 8'd1);
      tick();
      bus.Req_0 = 0;
      #1;
      chk("t2_busy", 8'(bus.Busy), 8'd1);
      chk("t2_dp_a", 8'(bus.Dp_A), 8'd3);
      chk("t2_dp_b", 8'(bus.Dp_B), 8'd4);
      chk("t2_dp_sel", 8'(bus.Dp_Sel), 8'd1);
      tick();
      #1;
      chk("t2_res0", 8'(bus.Res_0), 8'd7);
      chk("t2_vld0", 8'(bus.Res_Valid_0), 8'd1);
      tick();
      #1;
      chk("t2_vld0_hold", 8'(bus.Res_Valid_0), 8'd1);
      bus.Res_Ack_0 = 1;
      tick();
      bus.Res_Ack_0 = 0;
      #1;
      chk("t2_vld0_clr", 8'(bus.Res_Valid_0), 8'd0);
      chk("t2_res0_keep", 8'(bus.Res_0), 8'd7);
      tick();

      // 3: contention, rotation 0,1,0,1
      bus.Req_0 = 1;
      bus.Req_1 = 1;
      bus.A_0   = 4'd1;
      bus.A_1   = 4'd2;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         bus.Res_Ack_0 = m_v[0];
         bus.Res_Ack_1 = m_v[1];
         #1;
         chk($sformatf("t3_gnt_c%0d", k), 8'({bus.Gnt_1, bus.Gnt_0}),
             (k % 2 == 1) ? 8'd0 : ((k / 2) % 2 == 1 ? 8'd2 : 8'd1));
         tick();
      end
      idle_inputs();

      // 4: pending result blocks client 0, client 1 still served
      do_reset();
      bus.Req_0 = 1;
      bus.A_0   = 4'd1;
      bus.B_0   = 4'd1;
      bus.Req_1 = 1;
      bus.A_1   = 4'd15;
      bus.B_1   = 4'd2;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (k > 0) chk($sformatf("t4_no_gnt0_c%0d", k), 8'(bus.Gnt_0), 8'd0);
         tick();
      end
      #1;
      chk("t4_res1", 8'(bus.Res_1), 8'd1);
      chk("t4_vld", 8'({bus.Res_Valid_1, bus.Res_Valid_0}), 8'd3);
      idle_inputs();

      // 5: overflow wrap and ack with nothing pending
      do_reset();
      bus.Req_0 = 1;
      bus.A_0   = 4'd9;
      bus.B_0   = 4'd9;
      #1 tick();
      bus.Req_0 = 0;
      #1 tick();
      #1;
      chk("t5_res0", 8'(bus.Res_0), 8'd2);
      bus.Res_Ack_0 = 1;
      tick();
      #1;
      chk("t5_vld0", 8'(bus.Res_Valid_0), 8'd0);
      tick();
      bus.Res_Ack_0 = 0;
      #1;
      chk("t5_res0_keep", 8'(bus.Res_0), 8'd2);
      chk("t5_vld0_stay", 8'(bus.Res_Valid_0), 8'd0);
      tick();

      // 6: operand change after grant has no effect
      do_reset();
      bus.Req_1 = 1;
      bus.A_1   = 4'd5;
      bus.B_1   = 4'd6;
      bus.Sel_1 = 2'b11;
      #1 tick();
      bus.A_1   = 4'd0;
      bus.Req_1 = 0;
      #1;
      chk("t6_dp_a", 8'(bus.Dp_A), 8'd5);
      chk("t6_dp_sel", 8'(bus.Dp_Sel), 8'd3);
      tick();
      #1;
      chk("t6_res1", 8'(bus.Res_1), 8'd11);
      tick();

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         bus.Req_0     = 1'($urandom_range(0, 1));
         bus.Req_1     = 1'($urandom_range(0, 1));
         bus.A_0       = 4'($urandom);
         bus.B_0       = 4'($urandom);
         bus.A_1       = 4'($urandom);
         bus.B_1       = 4'($urandom);
         bus.Sel_0     = 2'($urandom);
         bus.Sel_1     = 2'($urandom);
         bus.Res_Ack_0 = ($urandom_range(0, 2) == 0);
         bus.Res_Ack_1 = ($urandom_range(0, 2) == 0);
         #1 tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
